// File: rtl/csa_tree_pipe_if.sv
// csa_tree_pipe_if: operand/result bundle for the pipelined multi-operand adder.
// The master drives the operand beat and the global advance; the slave (the adder)
// returns the resolved sum and its carry-save pair.
interface csa_tree_pipe_if #(
  parameter int SIZE_I = 32,
  parameter int DEPTH  = 10,
  parameter int SIZE_O = SIZE_I + $clog2(DEPTH)
);
  logic                         en;
  logic                         in_valid;
  logic                         in_first;
  logic                         in_last;
  logic [DEPTH-1:0][SIZE_I-1:0] A;
  logic                         out_valid;
  logic [SIZE_O-1:0]            out_sum;
  logic [1:0][SIZE_O-1:0]       out_cs;

  modport master (
    output en, in_valid, in_first, in_last, A,
    input  out_valid, out_sum, out_cs
  );

  modport slave (
    input  en, in_valid, in_first, in_last, A,
    output out_valid, out_sum, out_cs
  );
endinterface

// File: rtl/csa_tree_pipe.sv
// csa_tree_pipe: reduces DEPTH operands per beat through 3:2 carry-save layers,
// with a pipeline register after every REG_EVERY layers, an optional multi-beat
// carry-save accumulator, and a registered carry-propagate adder at the end.
// All arithmetic is modulo 2^SIZE_O.
module csa_tree_pipe #(
  parameter int SIZE_I    = 32,
  parameter int DEPTH     = 10,
  parameter int SIZE_O    = SIZE_I + $clog2(DEPTH),
  parameter int REG_EVERY = 1,
  parameter int ACC_EN    = 0
) (
  input logic            clk,
  input logic            reset,
  csa_tree_pipe_if.slave bus
);

  function automatic int next_rows(input int d);
    return 2 * (d / 3) + (d % 3);
  endfunction

  function automatic int count_layers(input int depth);
    int d;
    int n;
    d = depth;
    n = 0;
    while (d > 2) begin
      d = next_rows(d);
      n++;
    end
    return n;
  endfunction

  // Carry row of a 3:2 compressor: bitwise majority moved up one place,
  // the bit leaving the top of the word is dropped.
  function automatic logic [SIZE_O-1:0] carry_row(input logic [SIZE_O-1:0] x,
                                                  input logic [SIZE_O-1:0] y,
                                                  input logic [SIZE_O-1:0] z);
    logic [SIZE_O-1:0] m;
    m = (x & y) | (x & z) | (y & z);
    return m << 1;
  endfunction

  localparam int LAYERS  = count_layers(DEPTH);
  localparam bit REG_ON  = (REG_EVERY > 0);
  localparam int RE_SAFE = REG_ON ? REG_EVERY : 1;
  localparam int STAGES  = REG_ON ? (LAYERS + RE_SAFE - 1) / RE_SAFE : 0;
  localparam int NS      = (STAGES > 0) ? STAGES : 1;
  localparam int ROWS    = (DEPTH > 2) ? DEPTH : 2;

  typedef logic [ROWS-1:0][SIZE_O-1:0] rows_t;

  // Flags travel with the rows: {last, first, valid}.
  rows_t             stage_rows_d  [NS];
  rows_t             stage_rows_q  [NS];
  logic [2:0]        stage_flags_d [NS];
  logic [2:0]        stage_flags_q [NS];
  logic [SIZE_O-1:0] tree_s;
  logic [SIZE_O-1:0] tree_c;
  logic [2:0]        tree_flags;

  // Walk the layers in order; where a register is inserted, hand the rows to
  // it and carry on from its output, so one block describes the whole tree.
  always_comb begin
    rows_t      cur;
    rows_t      nxt;
    logic [2:0] cur_flags;
    int         d;
    int         s;
    cur = '0;
    nxt = '0;
    for (int i = 0; i < DEPTH; i++) cur[i] = SIZE_O'(bus.A[i]);
    cur_flags = {bus.in_last, bus.in_first, bus.in_valid};
    d = DEPTH;
    s = 0;
    for (int i = 0; i < NS; i++) begin
      stage_rows_d[i]  = '0;
      stage_flags_d[i] = '0;
    end
    for (int l = 0; l < LAYERS; l++) begin
      nxt = '0;
      for (int k = 0; k < d / 3; k++) begin
        nxt[2*k]   = cur[3*k] ^ cur[3*k+1] ^ cur[3*k+2];
        nxt[2*k+1] = carry_row(cur[3*k], cur[3*k+1], cur[3*k+2]);
      end
      for (int k = 0; k < d % 3; k++) nxt[2*(d/3)+k] = cur[3*(d/3)+k];
      cur = nxt;
      d   = next_rows(d);
      if (REG_ON && ((((l + 1) % RE_SAFE) == 0) || (l == LAYERS - 1))) begin
        stage_rows_d[s]  = cur;
        stage_flags_d[s] = cur_flags;
        cur              = stage_rows_q[s];
        cur_flags        = stage_flags_q[s];
        s++;
      end
    end
    tree_s     = cur[0];
    tree_c     = cur[1];
    tree_flags = cur_flags;
  end

  // Tree pipeline registers: en freezes them, reset drops any in-flight beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        stage_rows_q[i]  <= '0;
        stage_flags_q[i] <= '0;
      end
    end else if (bus.en) begin
      for (int i = 0; i < NS; i++) begin
        stage_rows_q[i]  <= stage_rows_d[i];
        stage_flags_q[i] <= stage_flags_d[i];
      end
    end
  end

  logic [SIZE_O-1:0] cpa_s;
  logic [SIZE_O-1:0] cpa_c;
  logic              cpa_v;

  if (ACC_EN != 0) begin : g_acc
    logic [SIZE_O-1:0] acc_s_d, acc_s_q, acc_c_d, acc_c_q;
    logic [SIZE_O-1:0] fwd_s_d, fwd_s_q, fwd_c_d, fwd_c_q;
    logic              fwd_v_d, fwd_v_q;

    // 4:2 compress the tree pair with the running pair (or zero on a first
    // beat); a last beat forwards the result and empties the accumulator.
    always_comb begin
      logic [SIZE_O-1:0] base_s, base_c, s1, c1, s2, c2;
      base_s  = tree_flags[1] ? '0 : acc_s_q;
      base_c  = tree_flags[1] ? '0 : acc_c_q;
      s1      = tree_s ^ tree_c ^ base_s;
      c1      = carry_row(tree_s, tree_c, base_s);
      s2      = s1 ^ c1 ^ base_c;
      c2      = carry_row(s1, c1, base_c);
      acc_s_d = acc_s_q;
      acc_c_d = acc_c_q;
      fwd_s_d = fwd_s_q;
      fwd_c_d = fwd_c_q;
      fwd_v_d = 1'b0;
      if (tree_flags[0]) begin
        if (tree_flags[2]) begin
          fwd_s_d = s2;
          fwd_c_d = c2;
          fwd_v_d = 1'b1;
          acc_s_d = '0;
          acc_c_d = '0;
        end else begin
          acc_s_d = s2;
          acc_c_d = c2;
        end
      end
    end

    // Accumulator and forward register; en freezes, reset clears.
    always_ff @(posedge clk) begin
      if (reset) begin
        acc_s_q <= '0;
        acc_c_q <= '0;
        fwd_s_q <= '0;
        fwd_c_q <= '0;
        fwd_v_q <= 1'b0;
      end else if (bus.en) begin
        acc_s_q <= acc_s_d;
        acc_c_q <= acc_c_d;
        fwd_s_q <= fwd_s_d;
        fwd_c_q <= fwd_c_d;
        fwd_v_q <= fwd_v_d;
      end
    end

    assign cpa_s = fwd_s_q;
    assign cpa_c = fwd_c_q;
    assign cpa_v = fwd_v_q;
  end else begin : g_no_acc
    logic unused_flags;
    assign unused_flags = ^tree_flags[2:1];
    assign cpa_s = tree_s;
    assign cpa_c = tree_c;
    assign cpa_v = tree_flags[0];
  end

  logic                   out_valid_d, out_valid_q;
  logic [SIZE_O-1:0]      out_sum_d, out_sum_q;
  logic [1:0][SIZE_O-1:0] out_cs_d, out_cs_q;

  // Resolve the pair; sum and pair load together and hold until the next result.
  always_comb begin
    out_valid_d = cpa_v;
    out_sum_d   = out_sum_q;
    out_cs_d    = out_cs_q;
    if (cpa_v) begin
      out_sum_d   = cpa_s + cpa_c;
      out_cs_d[0] = cpa_s;
      out_cs_d[1] = cpa_c;
    end
  end

  // Output register: en freezes it, reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cs_q    <= '0;
    end else if (bus.en) begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cs_q    <= out_cs_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cs    = out_cs_q;

endmodule

// File: tb/tb_csa_tree_pipe.sv
// tb_csa_tree_pipe: drives four adder configurations from one operand stream and
// compares each against a plain-arithmetic reference (sum of operands, optional
// per-frame accumulation, expected arrival counted in enabled clock edges).
module tb_csa_tree_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  csa_tree_pipe_if #(.SIZE_I(32), .DEPTH(10), .SIZE_O(36)) if0 ();
  csa_tree_pipe_if #(.SIZE_I(32), .DEPTH(10), .SIZE_O(36)) if1 ();
  csa_tree_pipe_if #(.SIZE_I(32), .DEPTH(10), .SIZE_O(32)) if2 ();
  csa_tree_pipe_if #(.SIZE_I(32), .DEPTH(2),  .SIZE_O(33)) if3 ();

  csa_tree_pipe #(.SIZE_I(32), .DEPTH(10), .SIZE_O(36), .REG_EVERY(1), .ACC_EN(0))
    u0 (.clk(clk), .reset(reset), .bus(if0));
  csa_tree_pipe #(.SIZE_I(32), .DEPTH(10), .SIZE_O(36), .REG_EVERY(1), .ACC_EN(1))
    u1 (.clk(clk), .reset(reset), .bus(if1));
  csa_tree_pipe #(.SIZE_I(32), .DEPTH(10), .SIZE_O(32), .REG_EVERY(2), .ACC_EN(1))
    u2 (.clk(clk), .reset(reset), .bus(if2));
  csa_tree_pipe #(.SIZE_I(32), .DEPTH(2),  .SIZE_O(33), .REG_EVERY(0), .ACC_EN(0))
    u3 (.clk(clk), .reset(reset), .bus(if3));

  // Latency = tree register stages + accumulator stage + CPA register.
  // DEPTH 10 has 5 layers: 5 stages at REG_EVERY=1, 3 stages at REG_EVERY=2.
  function automatic int lat_of(input int i);
    case (i)
      0: return 6;
      1: return 7;
      2: return 5;
      default: return 1;
    endcase
  endfunction

  function automatic bit acc_of(input int i);
    return (i == 1) || (i == 2);
  endfunction

  function automatic int width_of(input int i);
    case (i)
      0, 1: return 36;
      2: return 32;
      default: return 33;
    endcase
  endfunction

  function automatic int depth_of(input int i);
    return (i == 3) ? 2 : 10;
  endfunction

  function automatic logic [63:0] wrap(input logic [63:0] v, input int w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return v & m;
  endfunction

  typedef struct {
    int          inst;
    int          due;
    logic [63:0] val;
  } exp_t;

  exp_t             exp_q[$];
  logic [9:0][31:0] stim_a;
  logic [63:0]      acc_val  [4];
  logic [63:0]      last_sum [4];
  int               en_cnt;
  int               checks;
  int               failures;

  task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      $error("[TB] assertion on %s", tag);
    end
  endtask

  // Reference model for the coming edge: results are due a fixed number of
  // enabled edges after the beat that completes them.
  task automatic updateModel(input logic v, input logic f, input logic l,
                             input logic e, input logic r);
    logic [63:0] s;
    exp_t        item;
    if (r) begin
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
        acc_val[i]  = '0;
        last_sum[i] = '0;
      end
    end else if (e) begin
      en_cnt++;
      if (v) begin
        for (int i = 0; i < 4; i++) begin
          s = '0;
          for (int n = 0; n < depth_of(i); n++) s += 64'(stim_a[n]);
          item.inst = i;
          item.due  = en_cnt + lat_of(i) - 1;
          if (acc_of(i)) begin
            if (f) acc_val[i] = '0;
            acc_val[i] += s;
            if (l) begin
              item.val = wrap(acc_val[i], width_of(i));
              exp_q.push_back(item);
              acc_val[i] = '0;
            end
          end else begin
            item.val = wrap(s, width_of(i));
            exp_q.push_back(item);
          end
        end
      end
    end
  endtask

  task automatic checkOutput();
    logic        ev;
    logic [63:0] ex, ov, os, oc;
    int          w;
    for (int j = exp_q.size() - 1; j >= 0; j--)
      if (exp_q[j].due < en_cnt) exp_q.delete(j);
    for (int i = 0; i < 4; i++) begin
      w  = width_of(i);
      ev = 1'b0;
      ex = last_sum[i];
      for (int j = 0; j < exp_q.size(); j++) begin
        if (exp_q[j].inst == i && exp_q[j].due == en_cnt) begin
          ev = 1'b1;
          ex = exp_q[j].val;
        end
      end
      case (i)
        0: begin
          ov = {63'd0, if0.out_valid};
          os = 64'(if0.out_sum);
          oc = wrap(64'(if0.out_cs[0]) + 64'(if0.out_cs[1]), w);
        end
        1: begin
          ov = {63'd0, if1.out_valid};
          os = 64'(if1.out_sum);
          oc = wrap(64'(if1.out_cs[0]) + 64'(if1.out_cs[1]), w);
        end
        2: begin
          ov = {63'd0, if2.out_valid};
          os = 64'(if2.out_sum);
          oc = wrap(64'(if2.out_cs[0]) + 64'(if2.out_cs[1]), w);
        end
        default: begin
          ov = {63'd0, if3.out_valid};
          os = 64'(if3.out_sum);
          oc = wrap(64'(if3.out_cs[0]) + 64'(if3.out_cs[1]), w);
        end
      endcase
      compare($sformatf("u%0d_out_valid", i), ov, {63'd0, ev});
      compare($sformatf("u%0d_out_sum", i), os, ex);
      compare($sformatf("u%0d_out_cs_sum", i), oc, ex);
      last_sum[i] = ex;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic f, input logic l,
                               input logic e, input logic r);
    reset        = r;
    if0.en       = e;  if0.in_valid = v;  if0.in_first = f;  if0.in_last = l;
    if1.en       = e;  if1.in_valid = v;  if1.in_first = f;  if1.in_last = l;
    if2.en       = e;  if2.in_valid = v;  if2.in_first = f;  if2.in_last = l;
    if3.en       = e;  if3.in_valid = v;  if3.in_first = f;  if3.in_last = l;
    if0.A        = stim_a;
    if1.A        = stim_a;
    if2.A        = stim_a;
    if3.A        = stim_a[1:0];
    updateModel(v, f, l, e, r);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic setAll(input logic [31:0] v);
    for (int n = 0; n < 10; n++) stim_a[n] = v;
  endtask

  task automatic setRamp(input int k);
    for (int n = 0; n < 10; n++) stim_a[n] = 32'(n + k);
  endtask

  task automatic setRandom();
    for (int n = 0; n < 10; n++) stim_a[n] = $urandom;
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    en_cnt   = 0;
    stim_a   = '0;
    for (int i = 0; i < 4; i++) begin
      acc_val[i]  = '0;
      last_sum[i] = '0;
    end
    $display("[TB] csa_tree_pipe bench starting");

    // Reset held while en is low: reset must still clear everything.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // All-ones single beat: 10 x 0xFFFFFFFF, and the 32-bit wrapped version.
    setAll(32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    setAll(32'h0);
    idle(8);

    // Four back-to-back ramps A[n] = n + k.
    for (int k = 0; k < 4; k++) begin
      setRamp(k);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    idle(9);

    // Same stream with en low for two cycles in the middle.
    setRamp(0); applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    setRamp(1); applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    setRamp(2); applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    setRamp(3); applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(9);

    // Three-beat frame of ones, then an immediate single-beat frame of twos.
    setAll(32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    setAll(32'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(10);

    // Reset three cycles after an open-frame beat; a later beat without first
    // must accumulate from zero.
    setRandom();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(8);
    setRandom();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(8);

    // Two-operand combinational-tree instance: 5 + 7.
    stim_a    = '0;
    stim_a[0] = 32'd5;
    stim_a[1] = 32'd7;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(8);

    // Randomized beats, frame flags, stalls and the occasional reset.
    for (int t = 0; t < 80; t++) begin
      setRandom();
      applyStimulus(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
                    ($urandom % 5) != 0, ($urandom % 40) == 0);
    end
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
